// File: rtl/mgr_noc_locl_arb_if.sv
// Requester-side and NoC-side datapath signals of the manager local arbiter.
// The arbiter takes the slave view; the requesters and the NoC together form the master view.
interface mgr_noc_locl_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int TYPE_W  = 2,
    parameter int PTYPE_W = 3,
    parameter int DTYPE_W = 2
);
    logic [NUM_REQ-1:0]         req__arb__valid;
    logic [2*NUM_REQ-1:0]       req__arb__cntl;
    logic [TYPE_W*NUM_REQ-1:0]  req__arb__type;
    logic [PTYPE_W*NUM_REQ-1:0] req__arb__ptype;
    logic [DTYPE_W*NUM_REQ-1:0] req__arb__desttype;
    logic [NUM_REQ-1:0]         req__arb__pvalid;
    logic [DATA_W*NUM_REQ-1:0]  req__arb__data;
    logic [NUM_REQ-1:0]         arb__req__ready;

    logic                       locl__noc__dp_valid;
    logic [1:0]                 locl__noc__dp_cntl;
    logic [TYPE_W-1:0]          locl__noc__dp_type;
    logic [PTYPE_W-1:0]         locl__noc__dp_ptype;
    logic [DTYPE_W-1:0]         locl__noc__dp_desttype;
    logic                       locl__noc__dp_pvalid;
    logic [DATA_W-1:0]          locl__noc__dp_data;
    logic                       noc__locl__dp_ready;

    logic                       arb__err;
    logic [2:0]                 arb__grant_id;

    modport slave (
        input  req__arb__valid, req__arb__cntl, req__arb__type, req__arb__ptype,
               req__arb__desttype, req__arb__pvalid, req__arb__data, noc__locl__dp_ready,
        output arb__req__ready, locl__noc__dp_valid, locl__noc__dp_cntl, locl__noc__dp_type,
               locl__noc__dp_ptype, locl__noc__dp_desttype, locl__noc__dp_pvalid,
               locl__noc__dp_data, arb__err, arb__grant_id
    );

    modport master (
        output req__arb__valid, req__arb__cntl, req__arb__type, req__arb__ptype,
               req__arb__desttype, req__arb__pvalid, req__arb__data, noc__locl__dp_ready,
        input  arb__req__ready, locl__noc__dp_valid, locl__noc__dp_cntl, locl__noc__dp_type,
               locl__noc__dp_ptype, locl__noc__dp_desttype, locl__noc__dp_pvalid,
               locl__noc__dp_data, arb__err, arb__grant_id
    );
endinterface

// File: rtl/mgr_noc_locl_arb.sv
// Packet-granular round-robin arbiter sharing the local-to-NoC datapath; 1 clk requester-to-NoC latency.
// Backpressure via a 2-entry output FIFO: requester ready depends only on FIFO fullness, never on NoC ready.
module mgr_noc_locl_arb #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 64,
    parameter int TYPE_W  = 2,
    parameter int PTYPE_W = 3,
    parameter int DTYPE_W = 2
) (
    input  logic                    clk,
    input  logic                    reset_poll,
    mgr_noc_locl_arb_if.slave       bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    typedef struct packed {
        logic [1:0]         cntl;
        logic [TYPE_W-1:0]  pkt_type;
        logic [PTYPE_W-1:0] ptype;
        logic [DTYPE_W-1:0] desttype;
        logic               pvalid;
        logic [DATA_W-1:0]  data;
    } beat_t;

    logic [0:0]         state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      grant;
    logic               err;
    logic [2:0]         grant_id;

    beat_t              req_beat [NUM_REQ];
    beat_t              in_beat;
    logic               found;
    logic [IW-1:0]      sel;
    logic               bad_start;
    logic [NUM_REQ-1:0] ready;
    logic               push;

    beat_t              fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               fifo_full;
    logic               pop;
    beat_t              head;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    function automatic int wrap_add(input int a, input int b);
        int s;
        s = a + b;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_beat[i] = {bus.req__arb__cntl[2*i +: 2],
                           bus.req__arb__type[TYPE_W*i +: TYPE_W],
                           bus.req__arb__ptype[PTYPE_W*i +: PTYPE_W],
                           bus.req__arb__desttype[DTYPE_W*i +: DTYPE_W],
                           bus.req__arb__pvalid[i],
                           bus.req__arb__data[DATA_W*i +: DATA_W]};
        end
    end

    // First SOM-capable requester at or after rr_ptr; any non-SOM valid seen while arbitrating is an error.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        bad_start = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req__arb__valid[wrap_add(int'(rr_ptr), k)]
                       && bus.req__arb__cntl[2*wrap_add(int'(rr_ptr), k)]) begin
                found = 1'b1;
                sel   = IW'(wrap_add(int'(rr_ptr), k));
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req__arb__valid[i] && !bus.req__arb__cntl[2*i]) bad_start = 1'b1;
        end
    end

    always_comb begin
        ready = '0;
        if (!reset_poll) begin
            if (state == ST_LOCK)  ready[grant] = !fifo_full;
            else if (found)        ready[sel]   = !fifo_full;
        end
    end

    assign in_beat = req_beat[(state == ST_LOCK) ? grant : sel];
    assign push    = |(ready & bus.req__arb__valid);

    always_ff @(posedge clk or posedge reset_poll) begin
        if (reset_poll) begin
            state    <= ST_ARB;
            rr_ptr   <= '0;
            grant    <= '0;
            err      <= 1'b0;
            grant_id <= '0;
        end else if (state == ST_ARB) begin
            if (bad_start) err <= 1'b1;
            if (push) begin
                grant    <= sel;
                grant_id <= 3'(sel);
                if (in_beat.cntl[1]) rr_ptr <= next_idx(sel);
                else                 state  <= ST_LOCK;
            end
        end else if (push) begin
            // A start marker inside a locked packet is flagged but still forwarded.
            if (in_beat.cntl[0]) err <= 1'b1;
            if (in_beat.cntl[1]) begin
                state  <= ST_ARB;
                rr_ptr <= next_idx(grant);
            end
        end
    end

    assign fifo_full = (count == 2'd2);
    assign pop       = (count != 2'd0) && bus.noc__locl__dp_ready;

    always_ff @(posedge clk or posedge reset_poll) begin
        if (reset_poll) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head                       = fifo_mem[rd_ptr];
    assign bus.arb__req__ready        = ready;
    assign bus.locl__noc__dp_valid    = (count != 2'd0);
    assign bus.locl__noc__dp_cntl     = head.cntl;
    assign bus.locl__noc__dp_type     = head.pkt_type;
    assign bus.locl__noc__dp_ptype    = head.ptype;
    assign bus.locl__noc__dp_desttype = head.desttype;
    assign bus.locl__noc__dp_pvalid   = head.pvalid;
    assign bus.locl__noc__dp_data     = head.data;
    assign bus.arb__err               = err;
    assign bus.arb__grant_id          = grant_id;
endmodule

// File: tb/tb_mgr_noc_locl_arb.sv
// Randomized and directed bench for mgr_noc_locl_arb against a queue-based packet model.
`timescale 1ns/1ps
module tb_mgr_noc_locl_arb;
    localparam int NR = 3, DW = 64, TW = 2, PW = 3, DTW = 2;

    typedef struct packed {
        logic [1:0]     cntl;
        logic [TW-1:0]  typ;
        logic [PW-1:0]  ptype;
        logic [DTW-1:0] dtype;
        logic           pvalid;
        logic [DW-1:0]  data;
    } beat_t;

    logic clk = 1'b0;
    logic reset_poll = 1'b1;

    mgr_noc_locl_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .TYPE_W(TW), .PTYPE_W(PW), .DTYPE_W(DTW)) bus ();
    mgr_noc_locl_arb #(.NUM_REQ(NR), .DATA_W(DW), .TYPE_W(TW), .PTYPE_W(PW), .DTYPE_W(DTW)) dut (
        .clk(clk), .reset_poll(reset_poll), .bus(bus));

    always #5 clk = ~clk;

    beat_t rq [NR][$];     // beats each requester still has to send
    beat_t mq [$];         // model of what sits in the output FIFO, head first
    beat_t out_log [$];    // beats the DUT actually delivered to the NoC
    int    out_cyc [$];
    int    owner = -1, rr = 0, m_gid = 0;
    bit    m_err = 1'b0;
    int    n_chk = 0, n_pass = 0, cyc = 0;
    int    first_xfer = -1, first_out = -1;
    int    bubble_pct = 0, noc_pct = 100;
    bit    noc_force_low = 1'b0;
    logic [1:0] t1c [4] = '{2'b01, 2'b00, 2'b00, 2'b10};

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_pkt(int i, int len, logic [63:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.cntl   = (len == 1) ? 2'b11 : (k == 0) ? 2'b01 : (k == len-1) ? 2'b10 : 2'b00;
            b.typ    = TW'($urandom);
            b.ptype  = PW'(k);
            b.dtype  = DTW'($urandom);
            b.pvalid = 1'($urandom);
            b.data   = base + 64'(k);
            rq[i].push_back(b);
        end
    endtask

    task automatic drive();
        logic [NR-1:0] v, pv;
        logic [2*NR-1:0] c;
        logic [TW*NR-1:0] t;
        logic [PW*NR-1:0] p;
        logic [DTW*NR-1:0] d;
        logic [DW*NR-1:0] dat;
        beat_t b;
        v = '0; pv = '0; c = '0; t = '0; p = '0; d = '0; dat = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0 && $urandom_range(99) >= bubble_pct) begin
                b = rq[i][0];
                v[i] = 1'b1;
                c[2*i +: 2] = b.cntl;
                t[TW*i +: TW] = b.typ;
                p[PW*i +: PW] = b.ptype;
                d[DTW*i +: DTW] = b.dtype;
                pv[i] = b.pvalid;
                dat[DW*i +: DW] = b.data;
            end
        end
        bus.req__arb__valid = v;
        bus.req__arb__cntl = c;
        bus.req__arb__type = t;
        bus.req__arb__ptype = p;
        bus.req__arb__desttype = d;
        bus.req__arb__pvalid = pv;
        bus.req__arb__data = dat;
        bus.noc__locl__dp_ready = !noc_force_low && ($urandom_range(99) < noc_pct);
    endtask

    // Compares every output with the model, then advances the model by the coming clock edge.
    task automatic check_cycle();
        logic [NR-1:0] er, xfer;
        int sel, idx;
        bit bad;
        beat_t db, b;
        cyc++;
        db = {bus.locl__noc__dp_cntl, bus.locl__noc__dp_type, bus.locl__noc__dp_ptype,
              bus.locl__noc__dp_desttype, bus.locl__noc__dp_pvalid, bus.locl__noc__dp_data};
        if (reset_poll) begin
            mq.delete(); owner = -1; rr = 0; m_err = 1'b0; m_gid = 0;
            chk("rst_ready", bus.arb__req__ready, 0);
            chk("rst_dp_valid", bus.locl__noc__dp_valid, 0);
            chk("rst_err", bus.arb__err, 0);
            chk("rst_grant_id", bus.arb__grant_id, 0);
            return;
        end
        er = '0; bad = 1'b0; sel = -1;
        if (owner >= 0) er[owner] = (mq.size() < 2);
        else begin
            for (int k = 0; k < NR; k++) begin
                idx = (rr + k) % NR;
                if (sel < 0 && bus.req__arb__valid[idx] && bus.req__arb__cntl[2*idx]) sel = idx;
            end
            if (sel >= 0) er[sel] = (mq.size() < 2);
            for (int i = 0; i < NR; i++)
                if (bus.req__arb__valid[i] && !bus.req__arb__cntl[2*i]) bad = 1'b1;
        end
        chk("ready", bus.arb__req__ready, er);
        chk("dp_valid", bus.locl__noc__dp_valid, mq.size() > 0);
        if (mq.size() > 0) chk("dp_beat", db, mq[0]);
        chk("err", bus.arb__err, m_err);
        chk("grant_id", bus.arb__grant_id, m_gid);

        if (bus.locl__noc__dp_valid && bus.noc__locl__dp_ready) begin
            out_log.push_back(db);
            out_cyc.push_back(cyc);
        end
        if (first_xfer < 0 && |(bus.arb__req__ready & bus.req__arb__valid)) first_xfer = cyc;
        if (first_out < 0 && bus.locl__noc__dp_valid) first_out = cyc;

        xfer = er & bus.req__arb__valid;
        if (bad) m_err = 1'b1;
        if (bus.noc__locl__dp_ready && mq.size() > 0) void'(mq.pop_front());
        for (int i = 0; i < NR; i++) begin
            if (xfer[i]) begin
                b = rq[i].pop_front();
                mq.push_back(b);
                if (owner < 0) begin
                    m_gid = i;
                    if (b.cntl[1]) rr = (i + 1) % NR;
                    else owner = i;
                end else begin
                    if (b.cntl[0]) m_err = 1'b1;
                    if (b.cntl[1]) begin owner = -1; rr = (i + 1) % NR; end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit busy();
        busy = (mq.size() > 0);
        for (int i = 0; i < NR; i++) if (rq[i].size() > 0) busy = 1'b1;
    endfunction

    task automatic run_idle(string name, int max);
        int n;
        n = 0;
        while (busy() && n < max) begin cycle(); n++; end
        chk(name, busy(), 0);
        cycle(); cycle();
    endtask

    task automatic clear_log();
        out_log.delete(); out_cyc.delete();
        first_xfer = -1; first_out = -1;
    endtask

    task automatic do_reset();
        reset_poll = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        drive();
        cycle(); cycle();
        reset_poll = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with a request already pending: ready must stay low.
        push_pkt(0, 1, 64'hAA);
        drive();
        cycle(); cycle();
        rq[0].delete();
        drive();
        reset_poll = 1'b0;

        // Test 1: single 4-beat packet from requester 0.
        clear_log();
        push_pkt(0, 4, 64'h10);
        run_idle("t1_drain", 40);
        chk("t1_nbeats", out_log.size(), 4);
        if (out_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t1_cntl", out_log[k].cntl, t1c[k]);
                chk("t1_data", out_log[k].data, 64'h10 + 64'(k));
            end
            chk("t1_consecutive", out_cyc[3] - out_cyc[0], 3);
        end
        chk("t1_latency", first_out - first_xfer, 1);
        chk("t1_err", bus.arb__err, 0);

        // Test 2: everyone sends SOM_EOM back to back -> 0,1,2,0,1,2.
        do_reset();
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) push_pkt(i, 1, 64'h100 * 64'(i) + 64'(r));
        run_idle("t2_drain", 40);
        chk("t2_nbeats", out_log.size(), 6);
        if (out_log.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("t2_order", out_log[k].data[11:8], k % 3);
            chk("t2_6_in_6", out_cyc[5] - out_cyc[0], 5);
        end

        // Test 3: requester 0 must wait for requester 1's packet to finish.
        clear_log();
        push_pkt(1, 4, 64'h30);
        cycle(); cycle();
        push_pkt(0, 3, 64'h50);
        run_idle("t3_drain", 40);
        chk("t3_nbeats", out_log.size(), 7);
        if (out_log.size() == 7)
            for (int k = 0; k < 7; k++)
                chk("t3_no_interleave", out_log[k].data, (k < 4) ? 64'h30 + 64'(k) : 64'h50 + 64'(k - 4));

        // Test 4: NoC stalls 5 clks mid-packet.
        clear_log();
        push_pkt(0, 6, 64'h40);
        cycle(); cycle();
        noc_force_low = 1'b1;
        bus.noc__locl__dp_ready = 1'b0;
        repeat (5) cycle();
        chk("t4_stall_ready", bus.arb__req__ready[0], 0);
        chk("t4_stall_valid", bus.locl__noc__dp_valid, 1);
        noc_force_low = 1'b0;
        bus.noc__locl__dp_ready = 1'b1;
        run_idle("t4_drain", 40);
        chk("t4_nbeats", out_log.size(), 6);
        if (out_log.size() == 6)
            for (int k = 0; k < 6; k++) chk("t4_data", out_log[k].data, 64'h40 + 64'(k));

        // Test 5: MOM while arbitrating is a sticky error.
        clear_log();
        rq[2].push_back('{cntl: 2'b00, typ: 2'd1, ptype: 3'd2, dtype: 2'd3, pvalid: 1'b1, data: 64'hDEAD});
        drive();
        repeat (4) cycle();
        chk("t5_err", bus.arb__err, 1);
        chk("t5_ready2", bus.arb__req__ready[2], 0);
        rq[2].delete();
        drive();
        repeat (3) cycle();
        chk("t5_err_sticky", bus.arb__err, 1);

        // Test 6: asynchronous reset mid-packet, then a clean packet.
        clear_log();
        push_pkt(0, 5, 64'h60);
        repeat (3) cycle();
        #2;
        reset_poll = 1'b1;
        #1;
        chk("t6_async_valid", bus.locl__noc__dp_valid, 0);
        chk("t6_async_ready", bus.arb__req__ready, 0);
        chk("t6_async_err", bus.arb__err, 0);
        chk("t6_async_data", bus.locl__noc__dp_data, 0);
        rq[0].delete();
        cycle();
        reset_poll = 1'b0;
        clear_log();
        push_pkt(0, 2, 64'h70);
        run_idle("t6_drain", 40);
        chk("t6_nbeats", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("t6_data0", out_log[0].data, 64'h70);
            chk("t6_data1", out_log[1].data, 64'h71);
        end
        chk("t6_err", bus.arb__err, 0);

        // Random traffic with bubbles and NoC backpressure.
        bubble_pct = 20;
        noc_pct = 70;
        repeat (600) begin
            for (int i = 0; i < NR; i++)
                if (rq[i].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(i, $urandom_range(4, 1), {$urandom, $urandom});
            cycle();
        end
        bubble_pct = 0;
        noc_pct = 100;
        run_idle("rand_drain", 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
